// File: rtl/dhs_axil_apb_demux.sv
// AXI-Lite slave to multi-target APB master bridge.
// A rule table decodes each granted access onto one of NumSlv APB targets.
// Reads and writes strictly alternate under contention. Unmapped addresses
// return DECERR without any APB activity. Stalled accesses are aborted
// after TimeoutCycles ACCESS cycles.
module dhs_axil_apb_demux #(
    parameter int unsigned NumSlv        = 6,
    parameter int unsigned NumRules      = 8,
    parameter int unsigned AddrW         = 32,
    parameter int unsigned DataW         = 32,
    // Each rule is {idx, start, end}; rule 0 occupies the least significant bits.
    parameter logic [NumRules*($clog2(NumSlv)+2*AddrW)-1:0] Rules = {
        {3'd0, 32'h3000_0000, 32'h3000_000F},  // 7: SOC_CTRL alias
        {3'd0, 32'h2000_1000, 32'h2000_1FFF},  // 6: shadowed by rule 1
        {3'd5, 32'h2000_4000, 32'h2000_4FFF},  // 5: DMA
        {3'd3, 32'h0200_0000, 32'h0200_FFFF},  // 4: CLINT
        {3'd4, 32'h2000_3000, 32'h2000_3FFF},  // 3: PLIC
        {3'd1, 32'h2000_2000, 32'h2000_2FFF},  // 2: SPI
        {3'd2, 32'h2000_1000, 32'h2000_1FFF},  // 1: UART
        {3'd0, 32'h2000_0000, 32'h2000_0FFF}   // 0: SOC_CTRL
    },
    parameter int unsigned TimeoutCycles = 255,
    localparam int unsigned StrbW        = DataW / 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [AddrW-1:0]         aw_addr_i,
    input  logic [2:0]               aw_prot_i,
    input  logic                     aw_valid_i,
    output logic                     aw_ready_o,
    input  logic [DataW-1:0]         w_data_i,
    input  logic [StrbW-1:0]         w_strb_i,
    input  logic                     w_valid_i,
    output logic                     w_ready_o,
    output logic [1:0]               b_resp_o,
    output logic                     b_valid_o,
    input  logic                     b_ready_i,
    input  logic [AddrW-1:0]         ar_addr_i,
    input  logic [2:0]               ar_prot_i,
    input  logic                     ar_valid_i,
    output logic                     ar_ready_o,
    output logic [DataW-1:0]         r_data_o,
    output logic [1:0]               r_resp_o,
    output logic                     r_valid_o,
    input  logic                     r_ready_i,
    output logic [AddrW-1:0]         paddr_o,
    output logic [2:0]               pprot_o,
    output logic                     pwrite_o,
    output logic [DataW-1:0]         pwdata_o,
    output logic [StrbW-1:0]         pstrb_o,
    output logic [NumSlv-1:0]        psel_o,
    output logic                     penable_o,
    input  logic [NumSlv*DataW-1:0]  prdata_i,
    input  logic [NumSlv-1:0]        pready_i,
    input  logic [NumSlv-1:0]        pslverr_i,
    output logic                     timeout_o
);

    localparam int unsigned IdxW  = $clog2(NumSlv);
    localparam int unsigned RuleW = IdxW + 2 * AddrW;

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, RESP_W, RESP_R} state_e;

    state_e             state_q, state_d;
    logic               wr_prio_q, wr_prio_d;
    logic [AddrW-1:0]   paddr_q, paddr_d;
    logic [2:0]         pprot_q, pprot_d;
    logic               pwrite_q, pwrite_d;
    logic [DataW-1:0]   pwdata_q, pwdata_d;
    logic [StrbW-1:0]   pstrb_q, pstrb_d;
    logic [NumSlv-1:0]  psel_q, psel_d;
    logic               penable_q, penable_d;
    logic [IdxW-1:0]    sel_idx_q, sel_idx_d;
    logic [1:0]         resp_q, resp_d;
    logic [DataW-1:0]   rdata_q, rdata_d;
    logic [31:0]        cnt_q, cnt_d;
    logic               timeout_q, timeout_d;

    logic               wr_cand, rd_cand, grant_wr, grant_rd;
    logic [AddrW-1:0]   req_addr;
    logic               dec_hit;
    logic [IdxW-1:0]    dec_idx;

    // Arbitration: grant only from IDLE; the pointer breaks read/write ties.
    always_comb begin
        wr_cand  = rst_ni && (state_q == IDLE) && aw_valid_i && w_valid_i;
        rd_cand  = rst_ni && (state_q == IDLE) && ar_valid_i;
        grant_wr = wr_cand && (!rd_cand || wr_prio_q);
        grant_rd = rd_cand && !grant_wr;
        req_addr = grant_wr ? aw_addr_i : ar_addr_i;
    end

    assign aw_ready_o = grant_wr;
    assign w_ready_o  = grant_wr;
    assign ar_ready_o = grant_rd;

    // Address decode: the lowest-numbered matching rule wins.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int unsigned i = 0; i < NumRules; i++) begin
            if (!dec_hit
                && req_addr >= Rules[i*RuleW + AddrW +: AddrW]
                && req_addr <= Rules[i*RuleW +: AddrW]) begin
                dec_hit = 1'b1;
                dec_idx = Rules[i*RuleW + 2*AddrW +: IdxW];
            end
        end
    end

    // Next-state logic for the transaction FSM and its registered outputs.
    always_comb begin
        state_d   = state_q;
        wr_prio_d = wr_prio_q;
        paddr_d   = paddr_q;
        pprot_d   = pprot_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        sel_idx_d = sel_idx_q;
        resp_d    = resp_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant_wr || grant_rd) begin
                    wr_prio_d = grant_rd;
                    pwrite_d  = grant_wr;
                    paddr_d   = req_addr;
                    pprot_d   = grant_wr ? aw_prot_i : ar_prot_i;
                    pwdata_d  = grant_wr ? w_data_i : '0;
                    pstrb_d   = grant_wr ? w_strb_i : '0;
                    sel_idx_d = dec_idx;
                    rdata_d   = '0;
                    if (dec_hit) begin
                        psel_d  = NumSlv'(1) << dec_idx;
                        state_d = SETUP;
                    end else begin
                        resp_d  = 2'b11;
                        state_d = grant_wr ? RESP_W : RESP_R;
                    end
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // pready is checked first so a tie with the limit completes normally.
                if (pready_i[sel_idx_q]) begin
                    rdata_d   = pwrite_q ? '0 : prdata_i[int'(sel_idx_q)*DataW +: DataW];
                    resp_d    = pslverr_i[sel_idx_q] ? 2'b10 : 2'b00;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    state_d   = pwrite_q ? RESP_W : RESP_R;
                end else if (TimeoutCycles != 0 && cnt_q == TimeoutCycles - 1) begin
                    rdata_d   = '0;
                    resp_d    = 2'b10;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = pwrite_q ? RESP_W : RESP_R;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            RESP_W: if (b_ready_i) state_d = IDLE;
            RESP_R: if (r_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            wr_prio_q <= 1'b1;
            paddr_q   <= '0;
            pprot_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            sel_idx_q <= '0;
            resp_q    <= '0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_prio_q <= wr_prio_d;
            paddr_q   <= paddr_d;
            pprot_q   <= pprot_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            sel_idx_q <= sel_idx_d;
            resp_q    <= resp_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign paddr_o   = paddr_q;
    assign pprot_o   = pprot_q;
    assign pwrite_o  = pwrite_q;
    assign pwdata_o  = pwdata_q;
    assign pstrb_o   = pstrb_q;
    assign psel_o    = psel_q;
    assign penable_o = penable_q;
    assign b_valid_o = (state_q == RESP_W);
    assign r_valid_o = (state_q == RESP_R);
    assign b_resp_o  = resp_q;
    assign r_resp_o  = resp_q;
    assign r_data_o  = rdata_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_dhs_axil_apb_demux.sv
// Directed bench for dhs_axil_apb_demux with a response scoreboard and
// a configurable APB target model behind every psel bit.
module tb_dhs_axil_apb_demux;

    localparam int unsigned NS = 6;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned TO = 4;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic [AW-1:0]     aw_addr_i, ar_addr_i;
    logic [2:0]        aw_prot_i, ar_prot_i;
    logic              aw_valid_i, aw_ready_o, w_valid_i, w_ready_o;
    logic [DW-1:0]     w_data_i;
    logic [SW-1:0]     w_strb_i;
    logic [1:0]        b_resp_o, r_resp_o;
    logic              b_valid_o, b_ready_i, ar_valid_i, ar_ready_o;
    logic [DW-1:0]     r_data_o;
    logic              r_valid_o, r_ready_i;
    logic [AW-1:0]     paddr_o;
    logic [2:0]        pprot_o;
    logic              pwrite_o, penable_o, timeout_o;
    logic [DW-1:0]     pwdata_o;
    logic [SW-1:0]     pstrb_o;
    logic [NS-1:0]     psel_o, pready_i, pslverr_i;
    logic [NS*DW-1:0]  prdata_i;

    always #5 clk = ~clk;

    dhs_axil_apb_demux #(
        .NumSlv(NS), .NumRules(8), .AddrW(AW), .DataW(DW), .TimeoutCycles(TO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .aw_addr_i(aw_addr_i), .aw_prot_i(aw_prot_i), .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
        .w_data_i(w_data_i), .w_strb_i(w_strb_i), .w_valid_i(w_valid_i), .w_ready_o(w_ready_o),
        .b_resp_o(b_resp_o), .b_valid_o(b_valid_o), .b_ready_i(b_ready_i),
        .ar_addr_i(ar_addr_i), .ar_prot_i(ar_prot_i), .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o),
        .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_valid_o(r_valid_o), .r_ready_i(r_ready_i),
        .paddr_o(paddr_o), .pprot_o(pprot_o), .pwrite_o(pwrite_o), .pwdata_o(pwdata_o),
        .pstrb_o(pstrb_o), .psel_o(psel_o), .penable_o(penable_o),
        .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i),
        .timeout_o(timeout_o)
    );

    // APB target model: pready after wait_cfg ACCESS cycles unless hung.
    int unsigned  wait_cfg = 0;
    bit           hang_cfg = 1'b0;
    bit           err_cfg  = 1'b0;
    int           tgt_cfg  = 0;
    logic [31:0]  rdata_cfg = '0;
    int unsigned  acc_cnt = 0;

    always @(posedge clk) begin
        if (penable_o && (|psel_o)) acc_cnt <= acc_cnt + 1;
        else                        acc_cnt <= 0;
    end

    always_comb begin
        pready_i  = '0;
        pslverr_i = '0;
        prdata_i  = '0;
        for (int i = 0; i < NS; i++) begin
            pready_i[i]  = psel_o[i] && penable_o && !hang_cfg && (acc_cnt >= wait_cfg);
            pslverr_i[i] = psel_o[i] && penable_o && err_cfg;
            prdata_i[i*DW +: DW] = (i == tgt_cfg) ? rdata_cfg : (32'hDEAD_0000 | 32'(i));
        end
    end

    typedef struct {
        bit          wr;
        logic [1:0]  resp;
        logic [31:0] data;
        int          lat;
        bit          to;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cfg(input int tgt, input int unsigned wt, input bit hang, input bit err,
                       input logic [31:0] rd);
        tgt_cfg = tgt; wait_cfg = wt; hang_cfg = hang; err_cfg = err; rdata_cfg = rd;
    endtask

    // One transaction: drive at cycle 0, follow APB phases, check the response
    // against the scoreboard, stall one cycle, then handshake.
    task automatic do_txn(input string tag, input bit wr, input bit contend,
                          input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic [5:0] exp_psel, input logic [1:0] exp_resp,
                          input logic [31:0] exp_data, input int exp_lat, input bit exp_to);
        exp_t e;
        int   cyc;
        bit   seen;
        logic [1:0]  resp_snap;
        logic [31:0] data_snap;
        e.wr = wr; e.resp = exp_resp; e.data = exp_data; e.lat = exp_lat; e.to = exp_to;
        sb.push_back(e);
        aw_addr_i = addr; ar_addr_i = addr; w_data_i = data; w_strb_i = strb;
        aw_prot_i = 3'b010; ar_prot_i = 3'b001;
        aw_valid_i = wr || contend; w_valid_i = wr || contend; ar_valid_i = !wr || contend;
        #1;
        check({tag, ".aw_ready"}, aw_ready_o, wr);
        check({tag, ".w_ready"},  w_ready_o,  wr);
        check({tag, ".ar_ready"}, ar_ready_o, !wr);
        @(posedge clk); #1;
        aw_valid_i = 1'b0; w_valid_i = 1'b0; ar_valid_i = 1'b0;
        cyc = 1; seen = 1'b0;
        while (cyc < 40) begin
            if (cyc == 1) begin
                check({tag, ".psel_setup"}, psel_o, exp_psel);
                check({tag, ".penable_setup"}, penable_o, 1'b0);
                if (exp_psel != 0) begin
                    check({tag, ".paddr"}, paddr_o, addr);
                    check({tag, ".pwrite"}, pwrite_o, wr);
                    check({tag, ".pprot"}, pprot_o, wr ? 3'b010 : 3'b001);
                    if (wr) begin
                        check({tag, ".pwdata"}, pwdata_o, data);
                        check({tag, ".pstrb"}, pstrb_o, strb);
                    end
                end
            end
            if (cyc == 2 && exp_psel != 0) begin
                check({tag, ".psel_access"}, psel_o, exp_psel);
                check({tag, ".penable_access"}, penable_o, 1'b1);
            end
            if (b_valid_o || r_valid_o) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, ".response_seen"}, seen, 1'b1);
        check({tag, ".sb_nonempty"}, sb.size() > 0, 1'b1);
        if (!seen || sb.size() == 0) return;
        e = sb.pop_front();
        check({tag, ".latency"}, cyc, e.lat);
        check({tag, ".b_valid"}, b_valid_o, e.wr);
        check({tag, ".r_valid"}, r_valid_o, !e.wr);
        check({tag, ".resp"}, e.wr ? b_resp_o : r_resp_o, e.resp);
        if (!e.wr) check({tag, ".r_data"}, r_data_o, e.data);
        check({tag, ".timeout_pulse"}, timeout_o, e.to);
        check({tag, ".psel_idle"}, psel_o, 6'b0);
        check({tag, ".penable_idle"}, penable_o, 1'b0);
        resp_snap = e.wr ? b_resp_o : r_resp_o;
        data_snap = r_data_o;
        @(posedge clk); #1;
        check({tag, ".valid_held"}, e.wr ? b_valid_o : r_valid_o, 1'b1);
        check({tag, ".resp_stable"}, e.wr ? b_resp_o : r_resp_o, resp_snap);
        if (!e.wr) check({tag, ".data_stable"}, r_data_o, data_snap);
        check({tag, ".timeout_single"}, timeout_o, 1'b0);
        b_ready_i = e.wr; r_ready_i = !e.wr;
        aw_valid_i = 1'b1; w_valid_i = 1'b1; ar_valid_i = 1'b1;
        #1;
        check({tag, ".no_grant_in_handshake"}, {aw_ready_o, w_ready_o, ar_ready_o}, 3'b000);
        @(posedge clk); #1;
        aw_valid_i = 1'b0; w_valid_i = 1'b0; ar_valid_i = 1'b0;
        b_ready_i = 1'b0; r_ready_i = 1'b0;
        check({tag, ".valid_dropped"}, {b_valid_o, r_valid_o}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit stray;
        rst_ni = 1'b0;
        aw_addr_i = '0; ar_addr_i = '0; aw_prot_i = '0; ar_prot_i = '0;
        w_data_i = '0; w_strb_i = '0;
        aw_valid_i = 1'b1; w_valid_i = 1'b1; ar_valid_i = 1'b1;
        b_ready_i = 1'b0; r_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.readies", {aw_ready_o, w_ready_o, ar_ready_o}, 3'b000);
        check("rst.valids", {b_valid_o, r_valid_o}, 2'b00);
        check("rst.psel", psel_o, 6'b0);
        check("rst.penable", penable_o, 1'b0);
        check("rst.timeout", timeout_o, 1'b0);
        check("rst.paddr", paddr_o, 32'h0);
        check("rst.pwdata", pwdata_o, 32'h0);
        check("rst.r_data", r_data_o, 32'h0);
        aw_valid_i = 1'b0; w_valid_i = 1'b0; ar_valid_i = 1'b0;
        rst_ni = 1'b1;
        @(posedge clk); #1;

        // UART write, pready on first ACCESS cycle
        cfg(2, 0, 1'b0, 1'b0, 32'h0);
        do_txn("uart_wr", 1'b1, 1'b0, 32'h2000_1004, 32'hA5A5_0001, 4'hF,
               6'b000100, 2'b00, 32'h0, 3, 1'b0);
        // PLIC read with 3 wait states: pready lands on the 4th ACCESS cycle (timeout tie)
        cfg(4, 3, 1'b0, 1'b0, 32'h0000_00C3);
        do_txn("plic_rd_tie", 1'b0, 1'b0, 32'h2000_3010, 32'h0, 4'h0,
               6'b010000, 2'b00, 32'h0000_00C3, 6, 1'b0);
        // unmapped read
        do_txn("unmapped_rd", 1'b0, 1'b0, 32'h1000_0000, 32'h0, 4'h0,
               6'b000000, 2'b11, 32'h0, 1, 1'b0);
        // contention: write, read, write
        cfg(0, 0, 1'b0, 1'b0, 32'h0);
        do_txn("arb1_wr", 1'b1, 1'b1, 32'h2000_0010, 32'h0000_1111, 4'h3,
               6'b000001, 2'b00, 32'h0, 3, 1'b0);
        cfg(1, 0, 1'b0, 1'b0, 32'h1234_5678);
        do_txn("arb2_rd", 1'b0, 1'b1, 32'h2000_2000, 32'h0, 4'h0,
               6'b000010, 2'b00, 32'h1234_5678, 3, 1'b0);
        do_txn("arb3_wr", 1'b1, 1'b1, 32'h2000_2004, 32'h0000_2222, 4'hC,
               6'b000010, 2'b00, 32'h0, 3, 1'b0);
        // timeouts
        cfg(5, 0, 1'b1, 1'b0, 32'h0);
        do_txn("dma_wr_timeout", 1'b1, 1'b0, 32'h2000_4000, 32'h5555_AAAA, 4'hF,
               6'b100000, 2'b10, 32'h0, 6, 1'b1);
        cfg(4, 4, 1'b0, 1'b0, 32'h0000_00C3);
        do_txn("plic_rd_timeout", 1'b0, 1'b0, 32'h2000_3000, 32'h0, 4'h0,
               6'b010000, 2'b10, 32'h0, 6, 1'b1);
        // slave errors
        cfg(1, 1, 1'b0, 1'b1, 32'h0);
        do_txn("spi_wr_slverr", 1'b1, 1'b0, 32'h2000_2008, 32'h0000_0033, 4'h1,
               6'b000010, 2'b10, 32'h0, 4, 1'b0);
        cfg(1, 0, 1'b0, 1'b1, 32'hCAFE_F00D);
        do_txn("spi_rd_slverr", 1'b0, 1'b0, 32'h2000_200C, 32'h0, 4'h0,
               6'b000010, 2'b10, 32'hCAFE_F00D, 3, 1'b0);
        // decode boundaries and rule priority
        cfg(2, 0, 1'b0, 1'b0, 32'h0000_0011);
        do_txn("uart_end_incl", 1'b0, 1'b0, 32'h2000_1FFF, 32'h0, 4'h0,
               6'b000100, 2'b00, 32'h0000_0011, 3, 1'b0);
        do_txn("overlap_low_wins", 1'b0, 1'b0, 32'h2000_1000, 32'h0, 4'h0,
               6'b000100, 2'b00, 32'h0000_0011, 3, 1'b0);
        cfg(0, 0, 1'b0, 1'b0, 32'h0000_0022);
        do_txn("soc_end", 1'b0, 1'b0, 32'h2000_0FFF, 32'h0, 4'h0,
               6'b000001, 2'b00, 32'h0000_0022, 3, 1'b0);
        cfg(3, 0, 1'b0, 1'b0, 32'h0000_0044);
        do_txn("clint_rd", 1'b0, 1'b0, 32'h0200_BFF8, 32'h0, 4'h0,
               6'b001000, 2'b00, 32'h0000_0044, 3, 1'b0);
        do_txn("gap_rd_miss", 1'b0, 1'b0, 32'h2000_5000, 32'h0, 4'h0,
               6'b000000, 2'b11, 32'h0, 1, 1'b0);
        do_txn("below_wr_miss", 1'b1, 1'b0, 32'h1FFF_FFFF, 32'hFFFF_FFFF, 4'hF,
               6'b000000, 2'b11, 32'h0, 1, 1'b0);

        // reset during ACCESS: transaction is abandoned with no response
        cfg(2, 0, 1'b1, 1'b0, 32'h0);
        aw_addr_i = 32'h2000_1008; w_data_i = 32'h0BAD_0BAD; w_strb_i = 4'hF;
        aw_valid_i = 1'b1; w_valid_i = 1'b1;
        #1;
        check("midrst.grant", aw_ready_o, 1'b1);
        @(posedge clk); #1;
        aw_valid_i = 1'b0; w_valid_i = 1'b0;
        @(posedge clk); #1;
        check("midrst.in_access", {psel_o, penable_o}, {6'b000100, 1'b1});
        rst_ni = 1'b0;
        @(posedge clk); #1;
        check("midrst.psel", psel_o, 6'b0);
        check("midrst.penable", penable_o, 1'b0);
        check("midrst.b_valid", b_valid_o, 1'b0);
        rst_ni = 1'b1;
        b_ready_i = 1'b1; r_ready_i = 1'b1;
        stray = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (b_valid_o || r_valid_o || (|psel_o)) stray = 1'b1;
        end
        b_ready_i = 1'b0; r_ready_i = 1'b0;
        check("midrst.no_response", stray, 1'b0);

        // after reset the pointer favours write again
        cfg(0, 0, 1'b0, 1'b0, 32'h0);
        do_txn("post_rst_arb_wr", 1'b1, 1'b1, 32'h2000_0020, 32'h0000_7777, 4'hF,
               6'b000001, 2'b00, 32'h0, 3, 1'b0);

        check("sb.drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dhs_axil_apb_demux.md
Name: dhs_axil_apb_demux

Overview:
- Parametrised AXI-Lite slave to multi-target APB master bridge with a built-in address decoder.
- Generalises the fixed peripheral-link decode to NumSlv APB targets driven by a rule table.
- Adds read/write fairness, decode-error generation and a per-access APB timeout.
- Sits behind the peripheral crossbar master port, in front of SOC_CTRL, SPI, UART, CLINT, PLIC and DMA CSRs.

Parameters:
- NumSlv, 6, number of APB targets (psel bits).
- NumRules, 8, number of address rules.
- AddrW, 32, address width.
- DataW, 32, data width; StrbW = DataW/8.
- Rules, packed array of NumRules x {idx[$clog2(NumSlv)], start[AddrW], end[AddrW]}, address map; end is inclusive.
- TimeoutCycles, 255, maximum ACCESS cycles before abort; 0 disables the timeout.

Ports:
- clk_i in 1: clock.
- rst_ni in 1: reset; synchronous, active-low.
- aw_addr_i in AddrW; aw_prot_i in 3; aw_valid_i in 1; aw_ready_o out 1: AXI-Lite write address.
- w_data_i in DataW; w_strb_i in StrbW; w_valid_i in 1; w_ready_o out 1: write data.
- b_resp_o out 2; b_valid_o out 1; b_ready_i in 1: write response.
- ar_addr_i in AddrW; ar_prot_i in 3; ar_valid_i in 1; ar_ready_o out 1: read address.
- r_data_o out DataW; r_resp_o out 2; r_valid_o out 1; r_ready_i in 1: read data.
- paddr_o out AddrW; pprot_o out 3; pwrite_o out 1; pwdata_o out DataW; pstrb_o out StrbW: shared APB request.
- psel_o out NumSlv: one-hot select.
- penable_o out 1: APB enable.
- prdata_i in NumSlv*DataW; pready_i in NumSlv; pslverr_i in NumSlv: per-target APB response.
- timeout_o out 1: one-cycle pulse on each aborted access.

Behaviour:
- Reset (rst_ni low at posedge): FSM to IDLE; all ready/valid outputs, psel_o, penable_o and timeout_o are 0; the data/addr registers are 0; arbitration pointer favours write.
- FSM states are IDLE, SETUP, ACCESS, RESP_W, RESP_R.
- IDLE, write candidate: write is a candidate only when aw_valid_i and w_valid_i are both high.
- IDLE, read candidate: read is a candidate when ar_valid_i is high.
- IDLE, arbitration: if both are candidates, the pointer selects; after each grant the pointer flips to the other direction (strict alternation under contention).
- IDLE, grant: aw_ready_o and w_ready_o are asserted together (or ar_ready_o alone) combinationally in the grant cycle. Address, prot, data, strb and direction are captured.
- Decode: compare the captured address against all rules. The lowest-numbered matching rule wins. A match requires start <= addr <= end, unsigned.
- Decode hit: IDLE -> SETUP. psel_o[idx]=1, penable_o=0.
- Decode miss: no APB activity; go directly to RESP_W/RESP_R with resp=2'b11 (DECERR) and r_data_o=0. Response valid is asserted the cycle after the grant.
- SETUP -> ACCESS after exactly one cycle; penable_o=1.
- ACCESS, normal completion: hold until pready_i[idx]=1. In that cycle, sample prdata_i[idx] and pslverr_i[idx]. Resp = pslverr ? 2'b10 : 2'b00. Deassert psel/penable next cycle and go to RESP_*.
- ACCESS, timeout: a counter starts at 0 on entry to ACCESS. If it reaches TimeoutCycles with no pready, abort: drop psel/penable, resp=2'b10, r_data_o=0, timeout_o=1 for one cycle, go to RESP_*.
- Timeout tie: pready arriving in the same cycle the counter hits the limit counts as normal completion.
- RESP_W: b_valid_o held with stable b_resp_o until b_ready_i; then IDLE.
- RESP_R: r_valid_o and r_data_o/r_resp_o held stable until r_ready_i; then IDLE.
- No new grant is made in the cycle a response handshakes; the earliest next grant is the following cycle.
- Latency (hit, pready immediate): grant at cycle 0; SETUP at 1; ACCESS at 2; valid at 3.
- One transaction is outstanding at a time. APB outputs are stable from SETUP through ACCESS.
- Mid-operation reset: abandons the transaction at once. psel_o/penable_o are 0 after that edge; no response is ever issued for it.

Test Plan:
- Write 0x20001004 data 0xA5A5_0001 strb 0xF, UART (idx 2) pready on first ACCESS cycle -> psel_o=6'b000100 cycles 1-2, penable_o cycle 2, b_valid_o cycle 3, b_resp_o=00.
- Read 0x20003010, PLIC pready after 3 wait cycles with prdata 0x0000_00C3 -> r_data_o=0x0000_00C3, r_resp_o=00, r_valid_o at cycle 6.
- Read 0x10000000 (unmapped) -> psel_o stays 0; r_valid_o at cycle 1 with r_resp_o=11 and r_data_o=0.
- Read and write valid in the same cycle, twice back-to-back -> first grant is write, second is read; the third contended grant is write.
- TimeoutCycles=4, target never asserts pready -> after 4 ACCESS cycles psel_o drops, timeout_o pulses once, b_resp_o=10.
- Target asserts pslverr with pready -> resp=10. rst_ni low during ACCESS -> psel_o=0 and b_valid_o=0 next cycle, with no response afterwards.
